// File: rtl/costas_clock_divider.sv
// Runtime-programmable clock divider producing a period tick, a near-50% divided
// clock and an unlock window that is low in a guard band around each tick.
module costas_clock_divider #(
  parameter int CNT_W       = 10,
  parameter int DEFAULT_DIV = 30,
  parameter int GUARD_PRE   = 1,
  parameter int GUARD_POST  = 1
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             enable,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_value,
  input  logic             resync,
  output logic             tick,
  output logic             clk_out,
  output logic             unlock,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] div_active
);

  localparam logic [CNT_W-1:0] DMIN  = CNT_W'(GUARD_PRE + GUARD_POST + 2);
  localparam logic [CNT_W-1:0] DDEF  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] GPRE  = CNT_W'(GUARD_PRE);
  localparam logic [CNT_W-1:0] GPOST = CNT_W'(GUARD_POST);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] pending;
  logic [CNT_W-1:0] div_clamped;
  logic [CNT_W-1:0] c_nxt;
  logic [CNT_W-1:0] d_nxt;
  logic             wrap;

  // Outputs are decoded from the next count/ratio so they register alongside them.
  always_comb begin
    div_clamped = (div_value < DMIN) ? DMIN : div_value;
    wrap        = (count == div_active - ONE);
    c_nxt       = count;
    d_nxt       = div_active;
    if (resync) begin
      c_nxt = '0;
      d_nxt = div_load ? div_clamped : pending;
    end else if (enable) begin
      if (wrap) begin
        c_nxt = '0;
        d_nxt = pending;
      end else begin
        c_nxt = count + ONE;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      count      <= DDEF - ONE;
      div_active <= DDEF;
      pending    <= DDEF;
      tick       <= 1'b0;
      clk_out    <= 1'b0;
      unlock     <= 1'b0;
    end else begin
      count      <= c_nxt;
      div_active <= d_nxt;
      if (div_load) begin
        pending <= div_clamped;
      end
      tick    <= (c_nxt == '0);
      clk_out <= (c_nxt < (d_nxt >> 1));
      unlock  <= !((c_nxt >= d_nxt - GPRE) || (c_nxt <= GPOST));
    end
  end

endmodule
